// File: rtl/hs_insert_sort.sv
// High-score table maintainer: reads the table from a synchronous RAM, inserts a new score
// in descending order and writes back the shifted tail; a clear request zeroes the table.
module hs_insert_sort #(
  parameter int SCORE_W = 32,
  parameter int DEPTH   = 3,
  parameter int ADDR_W  = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               clr,
  input  logic [SCORE_W-1:0] new_score,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    rank,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [SCORE_W-1:0] rd_data,
  output logic               we,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [SCORE_W-1:0] wr_data
);

  localparam int IW = ADDR_W + 1;
  localparam logic [IW-1:0]      DEPTH_C = IW'(DEPTH);
  localparam logic [IW-1:0]      LAST_C  = IW'(DEPTH - 1);
  localparam logic [IW-1:0]      ZERO_I  = {IW{1'b0}};
  localparam logic [IW-1:0]      ONE_I   = IW'(1);
  localparam logic [ADDR_W-1:0]  ZERO_A  = {ADDR_W{1'b0}};
  localparam logic [SCORE_W-1:0] ZERO_S  = {SCORE_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_INSERT = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             state_r, state_nx;
  logic [IW-1:0]      i_r, i_nx;
  logic [SCORE_W-1:0] ns_r, ns_nx;
  logic [IW-1:0]      r_r, r_nx;
  logic [SCORE_W-1:0] tbl_r  [DEPTH];
  logic [SCORE_W-1:0] tbl_nx [DEPTH];
  logic [IW-1:0]      pos_s;

  logic               busy_r, busy_nx;
  logic               done_r, done_nx;
  logic [IW-1:0]      rank_r, rank_nx;
  logic [ADDR_W-1:0]  rd_addr_r, rd_addr_nx;
  logic               we_r, we_nx;
  logic [ADDR_W-1:0]  wr_addr_r, wr_addr_nx;
  logic [SCORE_W-1:0] wr_data_r, wr_data_nx;

  // Lowest index whose entry is strictly below the score; DEPTH when none is (ties rank below).
  function automatic logic [IW-1:0] find_pos(input logic [SCORE_W-1:0] s,
                                             input logic [SCORE_W-1:0] t [DEPTH]);
    logic [IW-1:0] p;
    p = DEPTH_C;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      p = (s > t[k]) ? IW'(k) : p;
    end
    return p;
  endfunction

  // Next-state, index counter and table buffer update.
  always_comb begin
    state_nx = state_r;
    i_nx     = i_r;
    ns_nx    = ns_r;
    r_nx     = r_r;
    tbl_nx   = tbl_r;
    pos_s    = find_pos(ns_r, tbl_r);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          ns_nx = new_score;
          i_nx  = ZERO_I;
          if (clr) begin
            r_nx = DEPTH_C;
            for (int k = 0; k < DEPTH; k++) begin
              tbl_nx[k] = ZERO_S;
            end
            state_nx = ST_WRITE;
          end else begin
            state_nx = ST_READ;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_READ: begin
        // RAM data lags the address by one cycle, so index i fills entry i-1.
        for (int k = 0; k < DEPTH; k++) begin
          tbl_nx[k] = (i_r == IW'(k + 1)) ? rd_data : tbl_r[k];
        end
        if (i_r == DEPTH_C) begin
          state_nx = ST_INSERT;
          i_nx     = ZERO_I;
        end else begin
          i_nx = i_r + ONE_I;
        end
      end
      ST_INSERT: begin
        r_nx = pos_s;
        if (pos_s == DEPTH_C) begin
          state_nx = ST_DONE;
        end else begin
          state_nx  = ST_WRITE;
          i_nx      = pos_s;
          tbl_nx[0] = (pos_s == ZERO_I) ? ns_r : tbl_r[0];
          for (int k = 1; k < DEPTH; k++) begin
            if (IW'(k) > pos_s) begin
              tbl_nx[k] = tbl_r[k-1];
            end else if (IW'(k) == pos_s) begin
              tbl_nx[k] = ns_r;
            end else begin
              tbl_nx[k] = tbl_r[k];
            end
          end
        end
      end
      ST_WRITE: begin
        if (i_r == LAST_C) begin
          state_nx = ST_DONE;
          i_nx     = ZERO_I;
        end else begin
          i_nx = i_r + ONE_I;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        i_nx     = ZERO_I;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the ports are registered.
  always_comb begin
    busy_nx    = (state_nx != ST_IDLE);
    done_nx    = (state_nx == ST_DONE);
    rank_nx    = done_nx ? r_nx : rank_r;
    rd_addr_nx = ((state_nx == ST_READ) && (i_nx < DEPTH_C)) ? i_nx[ADDR_W-1:0] : ZERO_A;
    we_nx      = (state_nx == ST_WRITE);
    wr_addr_nx = we_nx ? i_nx[ADDR_W-1:0] : ZERO_A;
    wr_data_nx = ZERO_S;
    for (int k = 0; k < DEPTH; k++) begin
      wr_data_nx = (we_nx && (i_nx == IW'(k))) ? tbl_nx[k] : wr_data_nx;
    end
  end

  // Control state and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      i_r       <= ZERO_I;
      ns_r      <= ZERO_S;
      r_r       <= ZERO_I;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rank_r    <= ZERO_I;
      rd_addr_r <= ZERO_A;
      we_r      <= 1'b0;
      wr_addr_r <= ZERO_A;
      wr_data_r <= ZERO_S;
    end else begin
      state_r   <= state_nx;
      i_r       <= i_nx;
      ns_r      <= ns_nx;
      r_r       <= r_nx;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
      rank_r    <= rank_nx;
      rd_addr_r <= rd_addr_nx;
      we_r      <= we_nx;
      wr_addr_r <= wr_addr_nx;
      wr_data_r <= wr_data_nx;
    end
  end

  // Table buffer; contents are meaningless until loaded, so it carries no reset.
  always_ff @(posedge Clk) begin
    tbl_r <= tbl_nx;
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign rank    = rank_r;
  assign rd_addr = rd_addr_r;
  assign we      = we_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;

endmodule

// File: tb/tb_hs_insert_sort.sv
// Randomised bench for hs_insert_sort: a RAM model plus a queue-based reference of the table
// predicts every write, the done cycle and the rank of each operation.
module tb_hs_insert_sort;

  localparam int SW = 32;
  localparam int D  = 3;
  localparam int AW = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic          clr;
  logic [SW-1:0] new_score;
  logic          busy;
  logic          done;
  logic [AW:0]   rank;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_data;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_data;

  logic [SW-1:0] ram    [1<<AW];
  logic [SW-1:0] ld_tab [1<<AW];
  logic          ld_en;
  logic [SW-1:0] mt     [D];

  int n_chk = 0;
  int n_err = 0;

  hs_insert_sort #(.SCORE_W(SW), .DEPTH(D), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .clr(clr), .new_score(new_score),
    .busy(busy), .done(done), .rank(rank), .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 Clk = ~Clk;

  // Synchronous RAM with a bench-side bulk load port.
  always @(posedge Clk) begin
    rd_data <= ram[rd_addr];
    if (ld_en) ram <= ld_tab;
    else if (we) ram[wr_addr] <= wr_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_tab(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic [SW-1:0] c);
    ld_tab[0] = a; ld_tab[1] = b; ld_tab[2] = c; ld_tab[3] = '0;
    mt[0] = a; mt[1] = b; mt[2] = c;
    ld_en = 1'b1;
    step();
    ld_en = 1'b0;
  endtask

  task automatic check_ram(input string tag);
    for (int k = 0; k < D; k++) check(tag, 64'(ram[k]), 64'(mt[k]));
  endtask

  task automatic run_op(input logic c, input logic [SW-1:0] sc, input bit extra_start);
    logic [SW-1:0] q[$];
    logic [SW-1:0] newtab [D];
    int pos, wfirst, ne, exp_done, cyc, nw, busy_bad, rd_bad, idle_bad, exp_rd;
    int ew_addr [D];
    logic [SW-1:0] ew_data [D];
    int ew_cyc [D];
    bit got;
    // reference: plain insertion into a descending list, lowest entry drops off
    pos = D;
    for (int k = 0; k < D; k++) q.push_back(mt[k]);
    if (c) begin
      for (int k = 0; k < D; k++) newtab[k] = '0;
      ne = D; wfirst = 1; exp_done = D + 1; pos = D;
      for (int k = 0; k < D; k++) begin
        ew_addr[k] = k; ew_data[k] = '0; ew_cyc[k] = wfirst + k;
      end
    end else begin
      for (int k = 0; k < D; k++) begin
        if (sc > mt[k]) begin pos = k; break; end
      end
      if (pos < D) begin
        q.insert(pos, sc);
        void'(q.pop_back());
      end
      for (int k = 0; k < D; k++) newtab[k] = q[k];
      ne = D - pos; wfirst = D + 3; exp_done = D + 3 + ne;
      for (int k = 0; k < ne; k++) begin
        ew_addr[k] = pos + k; ew_data[k] = newtab[pos + k]; ew_cyc[k] = wfirst + k;
      end
    end
    start = 1'b1; clr = c; new_score = sc;
    step();
    start = 1'b0; clr = 1'b0; new_score = $urandom;
    cyc = 1; nw = 0; got = 0; busy_bad = 0; rd_bad = 0; idle_bad = 0;
    while (cyc <= 40 && !got) begin
      if (extra_start && cyc == 2) begin start = 1'b1; new_score = $urandom; end
      if (extra_start && cyc == 3) start = 1'b0;
      exp_rd = (!c && cyc <= D) ? cyc - 1 : 0;
      if (rd_addr !== AW'(exp_rd)) rd_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (we === 1'b1) begin
        if (nw < ne) begin
          check("wr_addr", 64'(wr_addr), 64'(ew_addr[nw]));
          check("wr_data", 64'(wr_data), 64'(ew_data[nw]));
          check("wr_cycle", 64'(cyc), 64'(ew_cyc[nw]));
        end else begin
          check("extra_write", 64'(wr_addr), 64'(D + 100));
        end
        nw++;
      end else if (wr_addr !== '0 || wr_data !== '0) begin
        idle_bad++;
      end
      if (done === 1'b1) begin
        got = 1;
        check("done_cycle", 64'(cyc), 64'(exp_done));
        check("rank", 64'(rank), 64'(pos));
      end else begin
        step();
        cyc++;
      end
    end
    if (!got) check("done_timeout", 64'(0), 64'(1));
    check("write_count", 64'(nw), 64'(ne));
    check("busy_during_op", 64'(busy_bad), 64'(0));
    check("rd_addr_seq", 64'(rd_bad), 64'(0));
    check("idle_write_bus", 64'(idle_bad), 64'(0));
    step();
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_one_cycle", 64'(done), 64'(0));
    check("rank_held", 64'(rank), 64'(pos));
    for (int k = 0; k < D; k++) mt[k] = newtab[k];
    check_ram("ram_after_op");
  endtask

  initial begin
    logic [SW-1:0] rq[$];
    logic [SW-1:0] sc;
    int done_seen, we_seen;
    Reset = 1'b1; start = 1'b0; clr = 1'b0; new_score = '0; ld_en = 1'b0;
    for (int k = 0; k < (1<<AW); k++) ld_tab[k] = '0;
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rank", 64'(rank), 64'(0));
    check("rst_we", 64'(we), 64'(0));
    check("rst_rd_addr", 64'(rd_addr), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    Reset = 1'b0;

    // directed cases from the table-maintenance scenarios
    load_tab(32'd900, 32'd500, 32'd200); run_op(1'b0, 32'd600, 1'b0);
    load_tab(32'd900, 32'd500, 32'd200); run_op(1'b0, 32'd100, 1'b0);
    load_tab(32'd900, 32'd500, 32'd200); run_op(1'b0, 32'd500, 1'b0);
    load_tab(32'd900, 32'd500, 32'd200); run_op(1'b0, 32'd1000, 1'b0);
    run_op(1'b1, 32'd77, 1'b1);
    load_tab(32'hFFFF_FFFF, 32'h8000_0000, 32'd1); run_op(1'b0, 32'hFFFF_FFFE, 1'b0);

    // reset in cycle 7 of a full-shift insert: only addresses 0 and 1 get written
    load_tab(32'd900, 32'd500, 32'd200);
    start = 1'b1; new_score = 32'd1000;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 7; cyc++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_we", 64'(we), 64'(0));
    done_seen = 0; we_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1) done_seen++;
      if (we === 1'b1) we_seen++;
      step();
    end
    check("midrst_no_done", 64'(done_seen), 64'(0));
    check("midrst_no_write", 64'(we_seen), 64'(0));
    mt[0] = 32'd1000; mt[1] = 32'd900; mt[2] = 32'd200;
    check_ram("midrst_ram");
    run_op(1'b0, 32'd950, 1'b0);

    // randomised tables and scores, including ties and occasional clears
    for (int t = 0; t < 25; t++) begin
      rq.delete();
      for (int k = 0; k < D; k++) rq.push_back($urandom_range(0, 5000));
      rq.rsort();
      load_tab(rq[0], rq[1], rq[2]);
      for (int n = 0; n < 3; n++) begin
        case ($urandom_range(0, 3))
          0: sc = mt[$urandom_range(0, D-1)];
          1: sc = $urandom;
          2: sc = $urandom_range(0, 6000);
          default: sc = mt[$urandom_range(0, D-1)] + 32'd1;
        endcase
        run_op(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, sc, ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 1) step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hs_insert_sort.md
# hs_insert_sort

Parametrised high-score table maintainer for the game's end-of-round flow. On a start pulse it reads DEPTH scores from the synchronous high-score RAM, inserts a new score in descending order (the lowest entry drops off), and writes back only the entries that changed. A clear mode zeroes the whole table. It sits between the game-state controller, which issues start/clr and waits on done, and the high-score RAM.

## Interface
- SCORE_W, 32, score width in bits
- DEPTH, 3, number of table entries (≥2); entry 0 is the highest score
- ADDR_W, 2, RAM address width; 2^ADDR_W ≥ DEPTH
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- clr  in  1  sampled with start; 1 = clear table instead of insert
- new_score  in  SCORE_W  score to insert; latched when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the operation completes
- rank  out  ADDR_W+1  insert position (0..DEPTH-1), or DEPTH if the score did not qualify or a clear was performed; valid while done=1, held until the next accepted start
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  SCORE_W  RAM read data, valid one cycle after rd_addr
- we  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  SCORE_W  RAM write data

## Operation
- States: IDLE, READ, INSERT, WRITE, DONE. Internal buffer buf[0..DEPTH-1] of SCORE_W bits, index counter i, latched score ns, latched rank r.
- IDLE: if start=1, latch ns=new_score and clear i.
  - If clr=0, go to READ.
  - If clr=1, set r=DEPTH, fill buf with zeros and go to WRITE with write range 0..DEPTH-1.
- READ: runs for DEPTH+1 cycles, i=0..DEPTH.
  - For i<DEPTH, drive rd_addr=i.
  - For i>0, capture buf[i-1]=rd_data.
  - After i=DEPTH, go to INSERT.
- INSERT (1 cycle):
  - r = lowest index with ns > buf[r], using a strict unsigned compare. Ties rank below the existing entry.
  - If no such index exists, r=DEPTH and the next state is DONE with no writes.
  - Otherwise buf[k]=buf[k-1] for k=DEPTH-1 down to r+1, buf[r]=ns, and the next state is WRITE with range r..DEPTH-1.
- WRITE: one entry per cycle in ascending address order, we=1, wr_addr=k, wr_data=buf[k]. After the last entry, go to DONE.
- DONE (1 cycle): done=1, rank=r, then go to IDLE.
- start while busy=1 is ignored, with no queuing.
- Outputs in non-active cycles:
  - rd_addr=0 outside READ.
  - we=0, wr_addr=0 and wr_data=0 outside WRITE.

## Timing
- Reset: state IDLE, busy=0, done=0, rank=0, we=0, rd_addr=0, wr_addr=0, wr_data=0, i=0. buf contents are don't-care.
- Reset mid-operation (any state): the next cycle is IDLE, we=0 and done is not pulsed. Writes already issued remain in RAM, so the table may be partially updated; the controller owns any retry.
- Cycle numbering: start accepted in cycle 0.
  - Insert: READ occupies cycles 1..DEPTH+1, INSERT occupies cycle DEPTH+2, WRITE occupies DEPTH+3..DEPTH+2+W with W=DEPTH-r, and done=1 in cycle DEPTH+3+W.
  - Non-qualifying insert: done in cycle DEPTH+3.
  - Clear: WRITE occupies cycles 1..DEPTH, and done=1 in cycle DEPTH+1.
- busy rises in cycle 1 and falls in the cycle after done. A new start is accepted in the cycle after done at the earliest.
- Arithmetic: comparisons are unsigned at full SCORE_W; there is no truncation or saturation.

## Test plan
- DEPTH=3, RAM={900,500,200}, start with new_score=600 → writes (1,600) in cycle 6 and (2,500) in cycle 7, done in cycle 8 with rank=1; RAM={900,600,500}.
- Same table, new_score=100 → we never asserted, done in cycle 6 with rank=3; RAM unchanged.
- Same table, new_score=500 (tie) → single write (2,500) in cycle 6, done in cycle 7 with rank=2; RAM={900,500,500}.
- Same table, new_score=1000 → writes (0,1000), (1,900), (2,500) in cycles 6..8, done in cycle 9 with rank=0.
- start with clr=1 → writes zeros to addresses 0,1,2 in cycles 1..3, done in cycle 4 with rank=3. A second start pulsed during cycle 2 is ignored.
- Reset asserted in cycle 7 of the new_score=1000 case → only addresses 0 and 1 are written, busy=0 and we=0 from cycle 8, done is never pulsed. A subsequent start runs normally.
